// File: rtl/cp0_timer_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_timer_unit_if
//  Description : Register-port and interrupt bundle between the pipeline
//                (writeback / move-from-CP0 / fetch) and cp0_timer_unit.
//                Ports summary:
//                  write_enabled, address, write_data : register write port
//                  read_data                          : combinational read
//                  hardware_interrupt                 : raw external lines
//                  interrupt_enabled, exception_level : Status.IE / Status.EXL
//                  interrupt_pending, interrupt_request : interrupt outputs
//  Revision    : 1.0 - initial release
// ============================================================================
interface cp0_timer_unit_if #(
  parameter int TIMER_NUM  = 2,
  parameter int HW_IRQ_NUM = 6
);
  localparam int PEND_W = 2 + HW_IRQ_NUM + TIMER_NUM;

  logic                  write_enabled;
  logic [4:0]            address;
  logic [31:0]           write_data;
  logic [31:0]           read_data;
  logic [HW_IRQ_NUM-1:0] hardware_interrupt;
  logic                  interrupt_enabled;
  logic                  exception_level;
  logic [PEND_W-1:0]     interrupt_pending;
  logic                  interrupt_request;

  // Pipeline side
  modport master (
    output write_enabled, address, write_data, hardware_interrupt,
    output interrupt_enabled, exception_level,
    input  read_data, interrupt_pending, interrupt_request
  );

  // Timer unit side
  modport slave (
    input  write_enabled, address, write_data, hardware_interrupt,
    input  interrupt_enabled, exception_level,
    output read_data, interrupt_pending, interrupt_request
  );
endinterface
`default_nettype wire

// File: rtl/cp0_timer_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_timer_unit
//  Description : Coprocessor-0 timer and interrupt-source unit. Provides a
//                prescaled free-running count, TIMER_NUM compare channels,
//                per-line level/edge hardware interrupt capture, two software
//                interrupt bits and a masked interrupt request.
//                Ports summary:
//                  clock : sole clock
//                  reset : asynchronous active-low reset
//                  bus   : cp0_timer_unit_if.slave (register port, interrupt
//                          inputs, pending vector and request output)
//                Register map (5-bit address):
//                  0x00 count       0x01 control (timer enables)
//                  0x02 pending     0x03 mask     0x04 edge_mode
//                  0x08+i compare[i]
//                Pending bit order, LSB first: sw[1:0], hw lines, timers.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer_unit #(
  parameter int TIMER_NUM   = 2,
  parameter int HW_IRQ_NUM  = 6,
  parameter int COUNT_WIDTH = 32,
  parameter int TICK_DIVIDE = 2
) (
  input  wire logic       clock,
  input  wire logic       reset,
  cp0_timer_unit_if.slave bus
);

  localparam int PEND_W    = 2 + HW_IRQ_NUM + TIMER_NUM;
  localparam int HW_LSB    = 2;
  localparam int TIMER_LSB = 2 + HW_IRQ_NUM;
  localparam int PRE_W     = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;

  localparam logic [PRE_W-1:0]       PRE_LAST  = PRE_W'(TICK_DIVIDE - 1);
  localparam logic [PRE_W-1:0]       PRE_ONE   = PRE_W'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  localparam logic [4:0] ADDR_COUNT     = 5'h00;
  localparam logic [4:0] ADDR_CONTROL   = 5'h01;
  localparam logic [4:0] ADDR_PENDING   = 5'h02;
  localparam logic [4:0] ADDR_MASK      = 5'h03;
  localparam logic [4:0] ADDR_EDGE_MODE = 5'h04;
  localparam logic [4:0] ADDR_COMPARE   = 5'h08;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PRE_W-1:0]       prescaler_q,  prescaler_d;
  logic [COUNT_WIDTH-1:0] count_q,      count_d;
  logic [COUNT_WIDTH-1:0] compare_q [TIMER_NUM];
  logic [COUNT_WIDTH-1:0] compare_d [TIMER_NUM];
  logic [TIMER_NUM-1:0]   control_q,    control_d;
  logic [PEND_W-1:0]      mask_q,       mask_d;
  logic [HW_IRQ_NUM-1:0]  edge_mode_q,  edge_mode_d;
  logic [1:0]             sw_q,         sw_d;
  logic [TIMER_NUM-1:0]   timer_pend_q, timer_pend_d;
  logic [TIMER_NUM-1:0]   match_seen_q, match_seen_d;
  logic [HW_IRQ_NUM-1:0]  edge_pend_q,  edge_pend_d;
  logic [HW_IRQ_NUM-1:0]  sync_s1_q, sync_s2_q, sync_s3_q;

  // --------------------------------------------------------------------------
  // Write decode and compare match
  // --------------------------------------------------------------------------
  logic                  w_wr_count;
  logic                  w_wr_control;
  logic                  w_wr_pend;
  logic                  w_wr_mask;
  logic                  w_wr_edge_mode;
  logic [TIMER_NUM-1:0]  w_wr_compare;
  logic [TIMER_NUM-1:0]  w_match;
  logic [HW_IRQ_NUM-1:0] w_hw_rise;
  logic [HW_IRQ_NUM-1:0] w_hw_pend;
  logic [PEND_W-1:0]     w_pending;

  assign w_wr_count     = bus.write_enabled && (bus.address == ADDR_COUNT);
  assign w_wr_control   = bus.write_enabled && (bus.address == ADDR_CONTROL);
  assign w_wr_pend      = bus.write_enabled && (bus.address == ADDR_PENDING);
  assign w_wr_mask      = bus.write_enabled && (bus.address == ADDR_MASK);
  assign w_wr_edge_mode = bus.write_enabled && (bus.address == ADDR_EDGE_MODE);

  for (genvar gi = 0; gi < TIMER_NUM; gi++) begin : g_timer
    assign w_wr_compare[gi] = bus.write_enabled &&
                              (bus.address == (ADDR_COMPARE + 5'(gi)));
    assign w_match[gi]      = control_q[gi] && (count_q == compare_q[gi]);
  end

  assign w_hw_rise = sync_s2_q & ~sync_s3_q;
  // Level lines present the synchronised input; edge lines present the latch.
  assign w_hw_pend = (edge_mode_q & edge_pend_q) | (~edge_mode_q & sync_s2_q);
  assign w_pending = {timer_pend_q, w_hw_pend, sw_q};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    prescaler_d  = prescaler_q;
    count_d      = count_q;
    control_d    = control_q;
    mask_d       = mask_q;
    edge_mode_d  = edge_mode_q;
    sw_d         = sw_q;
    timer_pend_d = timer_pend_q;
    match_seen_d = w_match;
    edge_pend_d  = edge_pend_q;
    compare_d    = compare_q;

    // A count write restarts the prescaler so the loaded value is held for a
    // full TICK_DIVIDE period.
    if (w_wr_count) begin
      count_d     = bus.write_data[COUNT_WIDTH-1:0];
      prescaler_d = '0;
    end else if (prescaler_q == PRE_LAST) begin
      prescaler_d = '0;
      count_d     = count_q + COUNT_ONE;
    end else begin
      prescaler_d = prescaler_q + PRE_ONE;
    end

    if (w_wr_control)   control_d   = bus.write_data[TIMER_NUM-1:0];
    if (w_wr_mask)      mask_d      = bus.write_data[PEND_W-1:0];
    if (w_wr_edge_mode) edge_mode_d = bus.write_data[HW_IRQ_NUM-1:0];
    if (w_wr_pend)      sw_d        = bus.write_data[1:0];

    // Timer pending sets only on the first cycle of a match, so a write-1
    // clear during a multi-cycle match (TICK_DIVIDE >= 2) does not re-arm it.
    // Clears take priority over a simultaneous set.
    for (int i = 0; i < TIMER_NUM; i++) begin
      if (w_wr_compare[i]) compare_d[i] = bus.write_data[COUNT_WIDTH-1:0];
      if (w_match[i] && !match_seen_q[i]) timer_pend_d[i] = 1'b1;
      if ((w_wr_pend && bus.write_data[TIMER_LSB+i]) || w_wr_compare[i])
        timer_pend_d[i] = 1'b0;
    end

    // Edge latch: a new rising edge wins over a simultaneous write-1 clear.
    // Lines in level mode keep the latch at 0, so switching a line to edge
    // mode shows nothing until the next rising edge.
    if (w_wr_pend) edge_pend_d = edge_pend_d & ~bus.write_data[HW_LSB +: HW_IRQ_NUM];
    edge_pend_d = (edge_pend_d | w_hw_rise) & edge_mode_q;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler_q  <= '0;
      count_q      <= '0;
      control_q    <= '0;
      mask_q       <= '0;
      edge_mode_q  <= '0;
      sw_q         <= '0;
      timer_pend_q <= '0;
      match_seen_q <= '0;
      edge_pend_q  <= '0;
      sync_s1_q    <= '0;
      sync_s2_q    <= '0;
      sync_s3_q    <= '0;
      for (int i = 0; i < TIMER_NUM; i++) compare_q[i] <= '1;
    end else begin
      prescaler_q  <= prescaler_d;
      count_q      <= count_d;
      control_q    <= control_d;
      mask_q       <= mask_d;
      edge_mode_q  <= edge_mode_d;
      sw_q         <= sw_d;
      timer_pend_q <= timer_pend_d;
      match_seen_q <= match_seen_d;
      edge_pend_q  <= edge_pend_d;
      // External lines are asynchronous: two-flop synchroniser plus history.
      sync_s1_q    <= bus.hardware_interrupt;
      sync_s2_q    <= sync_s1_q;
      sync_s3_q    <= sync_s2_q;
      compare_q    <= compare_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read path (combinational, narrow registers zero-extended)
  // --------------------------------------------------------------------------
  logic [31:0] w_read_data;

  always_comb begin
    w_read_data = '0;
    case (bus.address)
      ADDR_COUNT:     w_read_data[COUNT_WIDTH-1:0] = count_q;
      ADDR_CONTROL:   w_read_data[TIMER_NUM-1:0]   = control_q;
      ADDR_PENDING:   w_read_data[PEND_W-1:0]      = w_pending;
      ADDR_MASK:      w_read_data[PEND_W-1:0]      = mask_q;
      ADDR_EDGE_MODE: w_read_data[HW_IRQ_NUM-1:0]  = edge_mode_q;
      default:        ;
    endcase
    for (int i = 0; i < TIMER_NUM; i++) begin
      if (bus.address == (ADDR_COMPARE + 5'(i)))
        w_read_data[COUNT_WIDTH-1:0] = compare_q[i];
    end
  end

  assign bus.read_data         = w_read_data;
  assign bus.interrupt_pending = w_pending;
  assign bus.interrupt_request = (|(w_pending & mask_q)) &
                                 bus.interrupt_enabled & ~bus.exception_level;

endmodule
`default_nettype wire

// File: tb/tb_cp0_timer_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_timer_unit
//  Description : Self-checking bench for cp0_timer_unit with TIMER_NUM=2,
//                HW_IRQ_NUM=6, COUNT_WIDTH=32, TICK_DIVIDE=2. Expected
//                values are pushed to a queue as stimulus is driven and
//                popped when the DUT output is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_timer_unit;

  localparam int TIMER_NUM  = 2;
  localparam int HW_IRQ_NUM = 6;
  localparam int PEND_W     = 2 + HW_IRQ_NUM + TIMER_NUM;
  localparam int TIMER0_BIT = 2 + HW_IRQ_NUM;  // 8
  localparam int HW2_BIT    = 4;

  logic clock;
  logic reset;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got;
  logic [31:0] e;

  cp0_timer_unit_if #(.TIMER_NUM(TIMER_NUM), .HW_IRQ_NUM(HW_IRQ_NUM)) bus ();

  cp0_timer_unit #(
    .TIMER_NUM  (TIMER_NUM),
    .HW_IRQ_NUM (HW_IRQ_NUM),
    .COUNT_WIDTH(32),
    .TICK_DIVIDE(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; leaves time 1 unit after the active edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Single-cycle register write; the write takes effect at the next edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.write_enabled = 1'b1;
    bus.address       = a;
    bus.write_data    = d;
    @(posedge clock);
    #1;
    bus.write_enabled = 1'b0;
    bus.write_data    = '0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [4:0]  addrs [9];
    logic [31:0] vals  [9];
    addrs = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08, 5'h09, 5'h05, 5'h0A};
    vals  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    // Reads are made while reset is held, so the clock cannot disturb them.
    for (int i = 0; i < 9; i++) exp_q.push_back(vals[i]);
    for (int i = 0; i < 9; i++) begin
      bus.address = addrs[i];
      #1;
      got = bus.read_data;
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_read[%0h]: got %h expected %h", addrs[i], got, e);
      end
    end
    checks++;
    if (bus.interrupt_pending !== '0 || bus.interrupt_request !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: pending %h request %b expected 0 0",
               bus.interrupt_pending, bus.interrupt_request);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_count();
    int steps [4];
    logic [31:0] vals [4];
    steps = '{0, 2, 8, 0};
    vals  = '{32'd0, 32'd1, 32'd5, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) wr(5'h00, 32'hFFFF_FFFF);
      repeat (steps[i]) step();
      exp_q.push_back(vals[i]);
      bus.address = 5'h00;
      #1;
      got = bus.read_data;
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL count_%0d: got %h expected %h", i, got, e);
      end
    end
    // Wrap modulo 2^32 after one full prescale period.
    repeat (2) step();
    exp_q.push_back(32'd0);
    bus.address = 5'h00;
    #1;
    got = bus.read_data;
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL count_wrap: got %h expected %h", got, e);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_timer();
    bus.interrupt_enabled = 1'b1;
    bus.exception_level   = 1'b0;
    wr(5'h01, 32'h1);
    wr(5'h08, 32'd10);
    wr(5'h03, 32'h1 << TIMER0_BIT);
    wr(5'h00, 32'd8);
    // Count reaches 10 after 4 clocks; pending follows one clock later.
    repeat (4) step();
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd0);
    bus.address = 5'h00;
    #1;
    got = bus.read_data;
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL timer_count_at_match: got %h expected %h", got, e);
    end
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.interrupt_request} !== e) begin
      errors++;
      $display("FAIL timer_req_before: got %b expected %h", bus.interrupt_request, e);
    end
    step();
    exp_q.push_back(32'd1);
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.interrupt_request} !== e) begin
      errors++;
      $display("FAIL timer_req_rise: got %b expected %h", bus.interrupt_request, e);
    end
    wr(5'h08, 32'd100);
    exp_q.push_back(32'd0);
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.interrupt_request} !== e) begin
      errors++;
      $display("FAIL timer_req_drop: got %b expected %h", bus.interrupt_request, e);
    end
    // Same match with EXL set: pending rises, request stays low.
    bus.exception_level = 1'b1;
    wr(5'h00, 32'd98);
    repeat (5) step();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.interrupt_pending[TIMER0_BIT]} !== e) begin
      errors++;
      $display("FAIL timer_exl_pending: got %b expected %h",
               bus.interrupt_pending[TIMER0_BIT], e);
    end
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.interrupt_request} !== e) begin
      errors++;
      $display("FAIL timer_exl_req: got %b expected %h", bus.interrupt_request, e);
    end
    // Write-1 clear while the match is still held; it must not re-arm.
    wr(5'h02, 32'h1 << TIMER0_BIT);
    step();
    exp_q.push_back(32'd0);
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.interrupt_pending[TIMER0_BIT]} !== e) begin
      errors++;
      $display("FAIL timer_w1c: got %b expected %h",
               bus.interrupt_pending[TIMER0_BIT], e);
    end
    bus.exception_level = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_compare_same_cycle();
    wr(5'h08, 32'd200);
    wr(5'h00, 32'd198);
    repeat (4) step();
    // Match is active this cycle; the compare write lands on the same edge.
    wr(5'h08, 32'd300);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'd0);
      e = exp_q.pop_front();
      checks++;
      if ({31'd0, bus.interrupt_pending[TIMER0_BIT]} !== e) begin
        errors++;
        $display("FAIL compare_same_cycle_%0d: got %b expected %h", i,
                 bus.interrupt_pending[TIMER0_BIT], e);
      end
      step();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_hw_level();
    logic [31:0] lvl_q [$];
    for (int c = 0; c < 10; c++) begin
      bus.hardware_interrupt[2] = (c < 5);
      lvl_q.push_back((c < 5) ? 32'd1 : 32'd0);
      step();
      // The pending bit reflects the line as driven one clock earlier.
      if (lvl_q.size() == 2) begin
        e = lvl_q.pop_front();
        checks++;
        if ({31'd0, bus.interrupt_pending[HW2_BIT]} !== e) begin
          errors++;
          $display("FAIL hw_level_c%0d: got %b expected %h", c,
                   bus.interrupt_pending[HW2_BIT], e);
        end
      end
    end
    lvl_q.delete();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_hw_edge();
    logic [31:0] seq [5];
    wr(5'h04, 32'h1 << 2);
    exp_q.push_back(32'd0);
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.interrupt_pending[HW2_BIT]} !== e) begin
      errors++;
      $display("FAIL hw_edge_switch: got %b expected %h",
               bus.interrupt_pending[HW2_BIT], e);
    end
    // One-cycle pulse: invisible after 1 edge, latched after 2, then held.
    seq = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1};
    bus.hardware_interrupt[2] = 1'b1;
    step();
    bus.hardware_interrupt[2] = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(seq[i]);
    for (int i = 0; i < 5; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({31'd0, bus.interrupt_pending[HW2_BIT]} !== e) begin
        errors++;
        $display("FAIL hw_edge_pulse_%0d: got %b expected %h", i,
                 bus.interrupt_pending[HW2_BIT], e);
      end
    end
    wr(5'h02, 32'h1 << HW2_BIT);
    exp_q.push_back(32'd0);
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.interrupt_pending[HW2_BIT]} !== e) begin
      errors++;
      $display("FAIL hw_edge_w1c: got %b expected %h",
               bus.interrupt_pending[HW2_BIT], e);
    end
    // New edge detected on the very edge of a write-1 clear: set wins.
    bus.hardware_interrupt[2] = 1'b1;
    step();
    bus.hardware_interrupt[2] = 1'b0;
    step();
    wr(5'h02, 32'h1 << HW2_BIT);
    exp_q.push_back(32'd1);
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.interrupt_pending[HW2_BIT]} !== e) begin
      errors++;
      $display("FAIL hw_edge_set_wins: got %b expected %h",
               bus.interrupt_pending[HW2_BIT], e);
    end
    wr(5'h02, 32'h1 << HW2_BIT);
    wr(5'h04, 32'h0);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_sw_mask();
    wr(5'h02, 32'h3);
    exp_q.push_back(32'h3);
    bus.address = 5'h02;
    #1;
    got = bus.read_data;
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL sw_pending_read: got %h expected %h", got, e);
    end
    // Narrow register keeps only PEND_W bits.
    wr(5'h03, 32'hFFFF_FFFF);
    exp_q.push_back(32'((1 << PEND_W) - 1));
    bus.address = 5'h03;
    #1;
    got = bus.read_data;
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL mask_zero_extend: got %h expected %h", got, e);
    end
    wr(5'h03, 32'h1);
    exp_q.push_back(32'd1);
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.interrupt_request} !== e) begin
      errors++;
      $display("FAIL sw_req_masked_in: got %b expected %h", bus.interrupt_request, e);
    end
    bus.interrupt_enabled = 1'b0;
    #1;
    exp_q.push_back(32'd0);
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.interrupt_request} !== e) begin
      errors++;
      $display("FAIL sw_req_ie_off: got %b expected %h", bus.interrupt_request, e);
    end
    bus.interrupt_enabled = 1'b1;
    wr(5'h03, 32'h0);
    exp_q.push_back(32'd0);
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.interrupt_request} !== e) begin
      errors++;
      $display("FAIL sw_req_masked_out: got %b expected %h", bus.interrupt_request, e);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_async_reset();
    logic [4:0]  addrs [4];
    logic [31:0] vals  [4];
    wr(5'h03, 32'h3);
    wr(5'h01, 32'h3);
    wr(5'h08, 32'd55);
    repeat (3) step();
    exp_q.push_back(32'd1);
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.interrupt_request} !== e) begin
      errors++;
      $display("FAIL areset_pre_req: got %b expected %h", bus.interrupt_request, e);
    end
    // Assert between edges; everything must clear without a clock edge.
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.interrupt_request !== 1'b0 || bus.interrupt_pending !== '0) begin
      errors++;
      $display("FAIL areset_irq: request %b pending %h expected 0 0",
               bus.interrupt_request, bus.interrupt_pending);
    end
    addrs = '{5'h00, 5'h08, 5'h03, 5'h01};
    vals  = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) exp_q.push_back(vals[i]);
    for (int i = 0; i < 4; i++) begin
      bus.address = addrs[i];
      #1;
      got = bus.read_data;
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL areset_read[%0h]: got %h expected %h", addrs[i], got, e);
      end
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    step();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    reset                  = 1'b0;
    bus.write_enabled      = 1'b0;
    bus.address            = '0;
    bus.write_data         = '0;
    bus.hardware_interrupt = '0;
    bus.interrupt_enabled  = 1'b0;
    bus.exception_level    = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    test_reset();
    test_count();
    test_timer();
    test_compare_same_cycle();
    test_hw_level();
    test_hw_edge();
    test_sw_mask();
    test_async_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
